// File: rtl/mem_store_queue_fwd.sv
// Store buffer between the core write path and a shared memory port.
// Holds address/data pairs in order, drains one entry per granted slot and
// forwards the youngest queued store data to a matching core load address.
module mem_store_queue_fwd #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 128,
    parameter int EDGE_MODE = 1,
    parameter int HWM       = DEPTH - 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     drain_en,
    input  logic                     flush,
    input  logic                     clr_ovf,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic [DATA_W-1:0]        out_data,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     out_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     ld_hit,
    output logic [DATA_W-1:0]        ld_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  valid_nxt;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     cnt;
    logic              wr_en_q;
    logic              ovf;
    logic              is_full;
    logic              is_empty;
    logic              push_req;
    logic              pop;
    logic              push_ok;
    logic              drop;
    logic [PW-1:0]     fwd_idx;

    assign is_full  = (cnt == CW'(DEPTH));
    assign is_empty = (cnt == '0);

    // Push/pop qualification; a full queue still accepts a push when the head drains on the same edge.
    always_comb begin
        push_req = (EDGE_MODE != 0) ? (wr_en & ~wr_en_q) : wr_en;
        pop      = drain_en & ~is_empty;
        push_ok  = push_req & (~is_full | pop);
        drop     = push_req & is_full & ~pop;
    end

    // Valid-bit update; when full with push and pop the tail equals the head, so the set wins.
    always_comb begin
        valid_nxt = valid;
        if (pop) begin
            valid_nxt[head] = 1'b0;
        end
        if (push_ok) begin
            valid_nxt[tail] = 1'b1;
        end
    end

    // Control state: pointers, occupancy, valid bits, edge detector and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            cnt      <= '0;
            valid    <= '0;
            wr_en_q  <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            // The edge detector keeps tracking wr_en across a flush so a held
            // request does not re-enqueue after the queue is discarded.
            wr_en_q <= wr_en;

            if (drop && !flush) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end

            if (flush) begin
                head  <= '0;
                tail  <= '0;
                cnt   <= '0;
                valid <= '0;
            end else begin
                if (pop) begin
                    head <= head + PW'(1);
                end
                if (push_ok) begin
                    tail <= tail + PW'(1);
                end
                if (push_ok && !pop) begin
                    cnt <= cnt + CW'(1);
                end else if (pop && !push_ok) begin
                    cnt <= cnt - CW'(1);
                end
                valid <= valid_nxt;
            end
        end
    end

    // Entry storage; contents are qualified by the valid bits so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem_data[tail] <= wr_data;
            mem_addr[tail] <= wr_addr;
        end
    end

    // Forwarding search walks oldest to youngest so the last match seen is the newest store.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        fwd_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head + PW'(i);
            if (valid[fwd_idx] && (mem_addr[fwd_idx] == ld_addr)) begin
                ld_hit  = 1'b1;
                ld_data = mem_data[fwd_idx];
            end
        end
    end

    // Head presentation and status flags; out_* read as zero while the queue is empty.
    always_comb begin
        out_data    = is_empty ? '0 : mem_data[head];
        out_addr    = is_empty ? '0 : mem_addr[head];
        out_valid   = pop;
        full        = is_full;
        empty       = is_empty;
        almost_full = (int'(cnt) >= HWM);
        count       = cnt;
        overflow    = ovf;
    end

endmodule

// File: tb/tb_mem_store_queue_fwd.sv
// Bench for mem_store_queue_fwd: three instances (edge/DEPTH4, level/DEPTH8,
// level/DEPTH16) share one stimulus bus and are tracked by a queue-based model.
module tb_mem_store_queue_fwd;

    localparam int M_DEPTH [3] = '{4, 8, 16};
    localparam int M_HWM   [3] = '{3, 4, 12};
    localparam int M_EDGE  [3] = '{1, 0, 0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = '0;
    logic [15:0] wr_addr = '0;
    logic        drain_en = 1'b0;
    logic        flush = 1'b0;
    logic        clr_ovf = 1'b0;
    logic [15:0] ld_addr = '0;

    logic [7:0]  o_data [3];
    logic [15:0] o_addr [3];
    logic [7:0]  l_data [3];
    logic        o_valid [3];
    logic        o_full [3];
    logic        o_empty [3];
    logic        o_af [3];
    logic        o_ovf [3];
    logic        o_hit [3];
    logic [2:0]  cnt0;
    logic [3:0]  cnt1;
    logic [4:0]  cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_store_queue_fwd #(.DATA_W(8), .ADDR_W(16), .DEPTH(4), .EDGE_MODE(1), .HWM(3)) u_d4e (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_addr(wr_addr),
        .drain_en(drain_en), .flush(flush), .clr_ovf(clr_ovf), .ld_addr(ld_addr),
        .out_data(o_data[0]), .out_addr(o_addr[0]), .out_valid(o_valid[0]), .full(o_full[0]),
        .empty(o_empty[0]), .almost_full(o_af[0]), .count(cnt0), .overflow(o_ovf[0]),
        .ld_hit(o_hit[0]), .ld_data(l_data[0]));

    mem_store_queue_fwd #(.DATA_W(8), .ADDR_W(16), .DEPTH(8), .EDGE_MODE(0)) u_d8l (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_addr(wr_addr),
        .drain_en(drain_en), .flush(flush), .clr_ovf(clr_ovf), .ld_addr(ld_addr),
        .out_data(o_data[1]), .out_addr(o_addr[1]), .out_valid(o_valid[1]), .full(o_full[1]),
        .empty(o_empty[1]), .almost_full(o_af[1]), .count(cnt1), .overflow(o_ovf[1]),
        .ld_hit(o_hit[1]), .ld_data(l_data[1]));

    mem_store_queue_fwd #(.DATA_W(8), .ADDR_W(16), .DEPTH(16), .EDGE_MODE(0)) u_d16l (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_addr(wr_addr),
        .drain_en(drain_en), .flush(flush), .clr_ovf(clr_ovf), .ld_addr(ld_addr),
        .out_data(o_data[2]), .out_addr(o_addr[2]), .out_valid(o_valid[2]), .full(o_full[2]),
        .empty(o_empty[2]), .almost_full(o_af[2]), .count(cnt2), .overflow(o_ovf[2]),
        .ld_hit(o_hit[2]), .ld_data(l_data[2]));

    // Reference model: one ordered queue of {addr,data} per instance.
    logic [23:0] mq [3][$];
    bit          m_ovf [3];
    bit          m_weq;

    task automatic m_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            m_ovf[k] = 1'b0;
        end
        m_weq = 1'b0;
    endtask

    task automatic m_step();
        for (int k = 0; k < 3; k++) begin
            bit push;
            bit pop;
            bit drop;
            int sz;
            sz   = mq[k].size();
            push = (M_EDGE[k] != 0) ? (wr_en && !m_weq) : wr_en;
            pop  = drain_en && (sz > 0);
            drop = push && (sz == M_DEPTH[k]) && !pop;
            if (flush) begin
                mq[k].delete();
            end else begin
                if (pop) void'(mq[k].pop_front());
                if (push && !drop) mq[k].push_back({wr_addr, wr_data});
            end
            if (clr_ovf) m_ovf[k] = 1'b0;
            if (drop && !flush) m_ovf[k] = 1'b1;
        end
        m_weq = wr_en;
    endtask

    always @(posedge clk) begin
        if (rst_n) m_step();
    end

    function automatic bit [23:0] m_head(int k);
        return (mq[k].size() > 0) ? mq[k][0] : 24'h0;
    endfunction

    function automatic bit [8:0] m_fwd(int k);
        bit [8:0] r;
        r = 9'h0;
        for (int i = 0; i < mq[k].size(); i++) begin
            if (mq[k][i][23:8] == ld_addr) r = {1'b1, mq[k][i][7:0]};
        end
        return r;
    endfunction

    function automatic int d_count(int k);
        case (k)
            0: return int'(cnt0);
            1: return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pulse(input logic [15:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
        step();
    endtask

    task automatic cleanup();
        wr_en = 1'b0; drain_en = 1'b0; flush = 1'b1; clr_ovf = 1'b1;
        step();
        flush = 1'b0; clr_ovf = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b1; wr_addr = 16'h1200; wr_data = 8'hAA; drain_en = 1'b1;
        m_reset();
        #3;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (o_empty[k] !== 1'b1) begin n_bad++; $display("FAIL reset_empty dut%0d got %b want 1", k, o_empty[k]); end
            n_cmp++; if (o_full[k] !== 1'b0) begin n_bad++; $display("FAIL reset_full dut%0d got %b want 0", k, o_full[k]); end
            n_cmp++; if (o_af[k] !== 1'b0) begin n_bad++; $display("FAIL reset_af dut%0d got %b want 0", k, o_af[k]); end
            n_cmp++; if (o_valid[k] !== 1'b0) begin n_bad++; $display("FAIL reset_valid dut%0d got %b want 0", k, o_valid[k]); end
            n_cmp++; if (o_hit[k] !== 1'b0) begin n_bad++; $display("FAIL reset_hit dut%0d got %b want 0", k, o_hit[k]); end
            n_cmp++; if ({o_addr[k], o_data[k], l_data[k]} !== 32'h0) begin n_bad++; $display("FAIL reset_data dut%0d got %h/%h/%h want 0", k, o_addr[k], o_data[k], l_data[k]); end
            n_cmp++; if (o_ovf[k] !== 1'b0) begin n_bad++; $display("FAIL reset_ovf dut%0d got %b want 0", k, o_ovf[k]); end
            n_cmp++; if (d_count(k) !== 0) begin n_bad++; $display("FAIL reset_count dut%0d got %0d want 0", k, d_count(k)); end
        end
        drain_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        @(negedge clk);
        n_cmp++; if (cnt0 !== 3'd1) begin n_bad++; $display("FAIL held_release_edge got %0d want 1", cnt0); end
        n_cmp++; if ({o_addr[0], o_data[0]} !== 24'h1200AA) begin n_bad++; $display("FAIL held_release_head got %h want 1200aa", {o_addr[0], o_data[0]}); end
        step();
        @(negedge clk);
        n_cmp++; if (cnt0 !== 3'd1) begin n_bad++; $display("FAIL held_second_edge got %0d want 1", cnt0); end
        n_cmp++; if (cnt2 !== 5'd2) begin n_bad++; $display("FAIL held_level got %0d want 2", cnt2); end
        step();
        cleanup();
    endtask

    task automatic test_basic_fifo();
        logic [23:0] exp_e [3];
        exp_e[0] = 24'h1200AA; exp_e[1] = 24'h2000BB; exp_e[2] = 24'h2001CC;
        for (int i = 0; i < 3; i++) push_pulse(exp_e[i][23:8], exp_e[i][7:0]);
        @(negedge clk);
        n_cmp++; if (cnt0 !== 3'd3) begin n_bad++; $display("FAIL basic_count got %0d want 3", cnt0); end
        step();
        drain_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (o_valid[0] !== 1'b1) begin n_bad++; $display("FAIL basic_valid%0d got %b want 1", i, o_valid[0]); end
            n_cmp++; if ({o_addr[0], o_data[0]} !== exp_e[i]) begin n_bad++; $display("FAIL basic_order%0d got %h want %h", i, {o_addr[0], o_data[0]}, exp_e[i]); end
            step();
        end
        drain_en = 1'b0;
        @(negedge clk);
        n_cmp++; if (o_empty[0] !== 1'b1) begin n_bad++; $display("FAIL basic_empty got %b want 1", o_empty[0]); end
        n_cmp++; if (o_valid[0] !== 1'b0) begin n_bad++; $display("FAIL basic_idle_valid got %b want 0", o_valid[0]); end
        step();
    endtask

    task automatic test_edge_vs_level();
        cleanup();
        wr_en = 1'b1; wr_addr = 16'h7000; wr_data = 8'h01;
        for (int i = 0; i < 10; i++) step();
        wr_en = 1'b0;
        @(negedge clk);
        n_cmp++; if (cnt0 !== 3'd1) begin n_bad++; $display("FAIL edge_hold got %0d want 1", cnt0); end
        n_cmp++; if (cnt2 !== 5'd10) begin n_bad++; $display("FAIL level_hold got %0d want 10", cnt2); end
        n_cmp++; if ({cnt1, o_full[1], o_ovf[1]} !== {4'd8, 1'b1, 1'b1}) begin n_bad++; $display("FAIL level_overfill got cnt=%0d full=%b ovf=%b want 8/1/1", cnt1, o_full[1], o_ovf[1]); end
        step();
        cleanup();
    endtask

    task automatic test_full_overflow();
        logic [23:0] exp_e [4];
        cleanup();
        for (int i = 0; i < 3; i++) push_pulse(16'h5000 + 16'(i), 8'h40 + 8'(i));
        @(negedge clk);
        n_cmp++; if ({o_af[0], o_full[0]} !== 2'b10) begin n_bad++; $display("FAIL hwm3 got af=%b full=%b want 1/0", o_af[0], o_full[0]); end
        step();
        push_pulse(16'h5003, 8'h43);
        @(negedge clk);
        n_cmp++; if ({cnt0, o_full[0], o_af[0]} !== {3'd4, 1'b1, 1'b1}) begin n_bad++; $display("FAIL fill4 got cnt=%0d full=%b af=%b want 4/1/1", cnt0, o_full[0], o_af[0]); end
        step();
        push_pulse(16'h5004, 8'h44);
        @(negedge clk);
        n_cmp++; if ({cnt0, o_ovf[0]} !== {3'd4, 1'b1}) begin n_bad++; $display("FAIL drop_push got cnt=%0d ovf=%b want 4/1", cnt0, o_ovf[0]); end
        step();
        wr_en = 1'b1; wr_addr = 16'h5005; wr_data = 8'h55; drain_en = 1'b1;
        @(negedge clk);
        n_cmp++; if ({o_valid[0], o_addr[0], o_data[0]} !== {1'b1, 24'h500040}) begin n_bad++; $display("FAIL full_pushpop_head got %b/%h want 1/500040", o_valid[0], {o_addr[0], o_data[0]}); end
        step();
        wr_en = 1'b0; drain_en = 1'b0;
        @(negedge clk);
        n_cmp++; if ({cnt0, o_full[0], o_ovf[0]} !== {3'd4, 1'b1, 1'b1}) begin n_bad++; $display("FAIL full_pushpop_count got cnt=%0d full=%b ovf=%b want 4/1/1", cnt0, o_full[0], o_ovf[0]); end
        step();
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        @(negedge clk);
        n_cmp++; if (o_ovf[0] !== 1'b0) begin n_bad++; $display("FAIL clr_ovf got %b want 0", o_ovf[0]); end
        step();
        exp_e[0] = 24'h500141; exp_e[1] = 24'h500242; exp_e[2] = 24'h500343; exp_e[3] = 24'h500555;
        drain_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if ({o_valid[0], o_addr[0], o_data[0]} !== {1'b1, exp_e[i]}) begin n_bad++; $display("FAIL full_order%0d got %b/%h want 1/%h", i, o_valid[0], {o_addr[0], o_data[0]}, exp_e[i]); end
            step();
        end
        drain_en = 1'b0;
    endtask

    task automatic test_forwarding();
        cleanup();
        push_pulse(16'h3000, 8'h11);
        push_pulse(16'h3000, 8'h22);
        ld_addr = 16'h3000;
        @(negedge clk);
        n_cmp++; if ({o_hit[0], l_data[0]} !== 9'h122) begin n_bad++; $display("FAIL fwd_youngest got %b/%h want 1/22", o_hit[0], l_data[0]); end
        step();
        ld_addr = 16'h3001;
        @(negedge clk);
        n_cmp++; if ({o_hit[0], l_data[0]} !== 9'h000) begin n_bad++; $display("FAIL fwd_miss got %b/%h want 0/00", o_hit[0], l_data[0]); end
        step();
        ld_addr = 16'h3000; drain_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++; if ({o_hit[0], l_data[0]} !== 9'h122) begin n_bad++; $display("FAIL fwd_popping%0d got %b/%h want 1/22", i, o_hit[0], l_data[0]); end
            step();
        end
        drain_en = 1'b0;
        @(negedge clk);
        n_cmp++; if ({o_hit[0], l_data[0]} !== 9'h000) begin n_bad++; $display("FAIL fwd_drained got %b/%h want 0/00", o_hit[0], l_data[0]); end
        step();
        ld_addr = 16'h3100; wr_en = 1'b1; wr_addr = 16'h3100; wr_data = 8'h77;
        @(negedge clk);
        n_cmp++; if (o_hit[0] !== 1'b0) begin n_bad++; $display("FAIL fwd_same_cycle_push got %b want 0", o_hit[0]); end
        step();
        wr_en = 1'b0;
        @(negedge clk);
        n_cmp++; if ({o_hit[0], l_data[0]} !== 9'h177) begin n_bad++; $display("FAIL fwd_next_cycle got %b/%h want 1/77", o_hit[0], l_data[0]); end
        step();
    endtask

    task automatic test_random();
        int n_push;
        int guard;
        cleanup();
        n_push = 0;
        guard = 0;
        while (n_push < 100 && guard < 2000) begin
            guard++;
            wr_en    = ($urandom_range(0, 99) < 60);
            wr_addr  = 16'h4000 + 16'($urandom_range(0, 7));
            wr_data  = 8'($urandom);
            drain_en = ($urandom_range(0, 1) == 1);
            ld_addr  = 16'h4000 + 16'($urandom_range(0, 7));
            clr_ovf  = ($urandom_range(0, 15) == 0);
            if (wr_en) n_push++;
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_cmp++; if (d_count(k) !== mq[k].size()) begin n_bad++; $display("FAIL rnd_count dut%0d got %0d want %0d", k, d_count(k), mq[k].size()); end
                n_cmp++; if ({o_empty[k], o_full[k], o_af[k]} !== {mq[k].size() == 0, mq[k].size() == M_DEPTH[k], mq[k].size() >= M_HWM[k]}) begin n_bad++; $display("FAIL rnd_flags dut%0d got e/f/af=%b%b%b size %0d", k, o_empty[k], o_full[k], o_af[k], mq[k].size()); end
                n_cmp++; if (o_ovf[k] !== m_ovf[k]) begin n_bad++; $display("FAIL rnd_ovf dut%0d got %b want %b", k, o_ovf[k], m_ovf[k]); end
                n_cmp++; if (o_valid[k] !== (drain_en && mq[k].size() > 0)) begin n_bad++; $display("FAIL rnd_valid dut%0d got %b", k, o_valid[k]); end
                n_cmp++; if ({o_addr[k], o_data[k]} !== m_head(k)) begin n_bad++; $display("FAIL rnd_head dut%0d got %h want %h", k, {o_addr[k], o_data[k]}, m_head(k)); end
                n_cmp++; if ({o_hit[k], l_data[k]} !== m_fwd(k)) begin n_bad++; $display("FAIL rnd_fwd dut%0d got %b/%h want %h", k, o_hit[k], l_data[k], m_fwd(k)); end
            end
            n_cmp++; if (cnt1 > 4'd8) begin n_bad++; $display("FAIL rnd_bound got %0d want <=8", cnt1); end
            step();
        end
        wr_en = 1'b0; drain_en = 1'b0; clr_ovf = 1'b0;
        n_cmp++; if (n_push < 100) begin n_bad++; $display("FAIL rnd_budget got %0d pushes want 100", n_push); end
    endtask

    task automatic test_flush_reset();
        cleanup();
        for (int i = 0; i < 5; i++) push_pulse(16'h6000 + 16'(i), 8'h60 + 8'(i));
        @(negedge clk);
        n_cmp++; if ({cnt0, cnt2, o_ovf[0]} !== {3'd4, 5'd5, 1'b1}) begin n_bad++; $display("FAIL pre_flush got %0d/%0d ovf=%b want 4/5/1", cnt0, cnt2, o_ovf[0]); end
        step();
        flush = 1'b1; wr_en = 1'b1; wr_addr = 16'h6100; wr_data = 8'h99; drain_en = 1'b1; ld_addr = 16'h6000;
        step();
        flush = 1'b0; drain_en = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if ({d_count(k) == 0, o_empty[k], o_hit[k]} !== 3'b110) begin n_bad++; $display("FAIL flush dut%0d got cnt=%0d empty=%b hit=%b want 0/1/0", k, d_count(k), o_empty[k], o_hit[k]); end
        end
        n_cmp++; if (o_ovf[0] !== 1'b1) begin n_bad++; $display("FAIL flush_keeps_ovf got %b want 1", o_ovf[0]); end
        step();
        @(negedge clk);
        n_cmp++; if ({cnt0, cnt2} !== {3'd0, 5'd1}) begin n_bad++; $display("FAIL flush_keeps_edge got %0d/%0d want 0/1", cnt0, cnt2); end
        step();
        cleanup();
        for (int i = 0; i < 3; i++) push_pulse(16'h6200 + 16'(i), 8'h70 + 8'(i));
        drain_en = 1'b1; ld_addr = 16'h6202;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if ({o_empty[k], o_full[k], o_af[k], o_valid[k], o_hit[k], o_ovf[k]} !== 6'b100000) begin n_bad++; $display("FAIL midreset_flags dut%0d got %b%b%b%b%b%b want 100000", k, o_empty[k], o_full[k], o_af[k], o_valid[k], o_hit[k], o_ovf[k]); end
            n_cmp++; if ({o_addr[k], o_data[k], l_data[k], d_count(k) == 0} !== {32'h0, 1'b1}) begin n_bad++; $display("FAIL midreset_data dut%0d got %h/%h/%h cnt=%0d want 0", k, o_addr[k], o_data[k], l_data[k], d_count(k)); end
        end
        m_reset();
        drain_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_basic_fifo();
        test_edge_vs_level();
        test_full_overflow();
        test_forwarding();
        test_random();
        test_flush_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_store_queue_fwd.md
Name: mem_store_queue_fwd

Overview:
Parametrised store-buffer FIFO between the CPU core bus and a shared memory/peripheral port. Captures CPU stores (address plus data) and drains them in order whenever the downstream port grants a write slot. Adds four things over the fixed-width queue: level or edge enqueue mode, store-to-load forwarding, an overflow flag, and a programmable high-water mark. It sits between addrDecoder write outputs and the BRAM/vector-RAM write port.

Parameters:
DATA_W, 8, store data width
ADDR_W, 16, store address width
DEPTH, 128, entry count; power of 2, at least 2
EDGE_MODE, 1, 1 = enqueue on rising edge of wr_en; 0 = enqueue every cycle wr_en is high
HWM, DEPTH-4, high-water threshold for the almost_full output

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  store request from core
wr_data  in  DATA_W  store data
wr_addr  in  ADDR_W  store address
drain_en  in  1  downstream grants one write this cycle
flush  in  1  synchronous discard of all entries
clr_ovf  in  1  synchronous clear of overflow
ld_addr  in  ADDR_W  core load address for forwarding lookup
out_data  out  DATA_W  head entry data
out_addr  out  ADDR_W  head entry address
out_valid  out  1  head entry is written downstream this cycle
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= HWM
count  out  clog2(DEPTH)+1  occupancy
overflow  out  1  sticky: a push was dropped
ld_hit  out  1  ld_addr matches a queued entry
ld_data  out  DATA_W  data of the youngest matching entry

Behaviour:
- Reset (async assert, sync release):
  - pointers, count, valid bits, edge register and overflow go to 0.
  - empty=1; full, almost_full, out_valid and ld_hit are 0; out_data, out_addr and ld_data are 0.
- Push strobe:
  - EDGE_MODE=1: push = wr_en & ~wr_en_q, where wr_en_q is registered and resets to 0. wr_en held high through reset release gives exactly one push on the first active edge.
  - EDGE_MODE=0: push = wr_en.
- Pop = drain_en & ~empty.
- out_* are combinational from the head entry. out_valid = pop. The downstream samples out_* in the same cycle.
- Full with push and pop in the same cycle: the push is accepted. The write goes to the tail slot vacated this edge; count stays DEPTH.
- Full with push and no pop: the push is dropped, overflow is set on that edge, and no state changes.
- Empty with push and drain_en: push only. The new entry is not visible on out_* until the next cycle; count becomes 1.
- Push only: count+1. Pop only: count-1. Both: count unchanged.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH with no special case.
- The popped entry's valid bit clears on the pop edge.
- flush:
  - Highest priority: pointers, count and all valid bits go to 0; push and pop in that cycle are ignored.
  - overflow and wr_en_q are not affected.
- clr_ovf clears overflow. If a dropped push occurs in the same cycle, set wins.
- Forwarding:
  - Combinational search over valid entries from youngest (tail-1) back to head.
  - ld_hit=1 and ld_data = newest matching data on any address match.
  - An entry popping this cycle still counts as a hit. A push this cycle is not visible until the next cycle.
  - With no match, ld_hit=0 and ld_data=0.
- almost_full and full are combinational from count.
- Latency: 1 cycle from push edge to visibility on out_*, count or ld_hit.

Test Plan:
- Reset, then 3 edge pushes (0x1200/0xAA, 0x2000/0xBB, 0x2001/0xCC) with drain_en=0 -> count=3. Hold drain_en=1 -> out_* shows 0x1200/0xAA, 0x2000/0xBB, 0x2001/0xCC on 3 consecutive cycles with out_valid=1; then empty=1.
- EDGE_MODE=1, wr_en held high 10 cycles -> exactly 1 entry queued. EDGE_MODE=0, same stimulus -> 10 entries queued.
- DEPTH=4:
  - fill 4 -> full=1 and almost_full=1 (HWM=3).
  - 5th push alone -> dropped, overflow=1, count=4.
  - push with drain_en -> accepted, count=4, order preserved.
  - clr_ovf -> overflow=0.
- Push 0x3000/0x11, then 0x3000/0x22; ld_addr=0x3000 -> ld_hit=1, ld_data=0x22. Drain both -> ld_hit=0.
- Push 100 entries over DEPTH=8 with random drain_en -> scoreboard order matches and pointers wrap cleanly; count never exceeds 8.
- Assert flush with 5 entries queued plus a simultaneous push -> count=0, empty=1, ld_hit=0. Drop rst_n mid-drain -> all outputs at reset values immediately, before any clock edge.
